lfsr_ctrl: RTL and testbench

Command-driven sequencer for the 8-bit LFSR datapath in the TinyTapeout top level. It loads seeds, holds the tap mask, and steps the LFSR core a programmed number of times. Each resulting state is presented on a valid/ready output port, one sample per step. It sits between the `ui_in`/`uio` pin decode and the LFSR core, and owns every control input of that core.

---
 rtl/lfsr_ctrl.sv | 163 ++++++++++++++++
 tb/tb_lfsr_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_ctrl.sv
// Command-driven sequencer for the 8-bit LFSR core: seed/tap registers, stepped runs, valid/ready sample port.
// Define LFSR_CTRL_LOCKUP_EN to enable zero-state detection and recovery (sticky lockup flag).
module lfsr_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             lfsr_load,
    output logic [WIDTH-1:0] lfsr_seed,
    output logic             lfsr_step,
    output logic [WIDTH-1:0] lfsr_taps,
    input  logic [WIDTH-1:0] lfsr_q,
    output logic             busy,
    output logic             done,
    output logic             lockup
);

    // state | meaning
    // IDLE  | accepting LOAD/TAPS/RUN/STOP
    // LOAD  | core loads seed this cycle
    // STEP  | core advances one step this cycle
    // CAPT  | capture core state into the output register
    // HOLD  | sample presented, waiting for transfer
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_STEP = 3'd2;
    localparam logic [2:0] S_CAPT = 3'd3;
    localparam logic [2:0] S_HOLD = 3'd4;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_TAPS = 2'b01;
    localparam logic [1:0] OP_RUN  = 2'b10;
    localparam logic [1:0] OP_STOP = 2'b11;

    localparam logic [WIDTH-1:0] SEED_RST = WIDTH'(8'h01);
    localparam logic [WIDTH-1:0] TAPS_RST = WIDTH'(8'hB8);
    localparam logic [CNT_W:0]   CNT_ONE  = (CNT_W+1)'(1);

    logic [2:0]       r_state;
    logic [WIDTH-1:0] r_seed;
    logic [WIDTH-1:0] r_taps;
    logic [CNT_W:0]   r_remaining;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_done;
    logic             r_lockup;

    logic             w_run;
    logic             w_idle;
    logic             w_cmd_fire;
    logic             w_stop;
    logic             w_xfer;
    logic             w_last;
    logic [CNT_W:0]   w_count;
    logic             w_capt_fix;
    logic             w_zero_load;
    logic [WIDTH-1:0] w_seed_in;

    assign w_run      = rst_n & ena;
    assign w_idle     = (r_state == S_IDLE);
    assign w_cmd_fire = cmd_valid & cmd_ready;
    assign w_stop     = w_cmd_fire & (cmd_op == OP_STOP) & ~w_idle;
    assign w_xfer     = ena & r_out_valid & out_ready & (r_state == S_HOLD);
    assign w_last     = (r_remaining == CNT_ONE);

    // A count of zero runs the full 2^CNT_W steps, hence the extra bit.
    assign w_count = (cmd_data[CNT_W-1:0] == '0) ? {1'b1, {CNT_W{1'b0}}}
                                                 : {1'b0, cmd_data[CNT_W-1:0]};

`ifdef LFSR_CTRL_LOCKUP_EN
    assign w_capt_fix  = w_run & (r_state == S_CAPT) & (lfsr_q == '0);
    assign w_zero_load = (cmd_data == '0);
    assign w_seed_in   = w_zero_load ? SEED_RST : cmd_data;
`else
    assign w_capt_fix  = 1'b0;
    assign w_zero_load = 1'b0;
    assign w_seed_in   = cmd_data;
`endif

    assign cmd_ready = w_run & (w_idle | (cmd_op == OP_STOP));
    assign lfsr_load = w_run & ((r_state == S_LOAD) | w_capt_fix);
    assign lfsr_step = w_run & (r_state == S_STEP);
    assign lfsr_seed = w_capt_fix ? SEED_RST : r_seed;
    assign lfsr_taps = r_taps;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = ~w_idle;
    assign done      = ena & r_done;
    assign lockup    = r_lockup;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_seed      <= SEED_RST;
            r_taps      <= TAPS_RST;
            r_remaining <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_lockup    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (ena) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_cmd_fire) begin
                            case (cmd_op)
                                OP_LOAD: begin
                                    r_seed   <= w_seed_in;
                                    r_lockup <= w_zero_load;
                                    r_state  <= S_LOAD;
                                end
                                OP_TAPS: r_taps <= cmd_data;
                                OP_RUN: begin
                                    r_remaining <= w_count;
                                    r_state     <= S_STEP;
                                end
                                default: ;
                            endcase
                        end
                    end
                    S_LOAD: r_state <= S_IDLE;
                    S_STEP: r_state <= S_CAPT;
                    S_CAPT: begin
                        r_out_data  <= lfsr_q;
                        r_out_valid <= 1'b1;
                        r_state     <= S_HOLD;
                        if (w_capt_fix) r_lockup <= 1'b1;
                    end
                    S_HOLD: begin
                        if (w_xfer) begin
                            r_remaining <= r_remaining - CNT_ONE;
                            r_out_valid <= 1'b0;
                            if (w_last) begin
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_state <= S_STEP;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
                // STOP overrides whatever the run was doing, including a final transfer.
                if (w_stop) begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_done      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_ctrl.sv
// Directed bench for lfsr_ctrl with a behavioural Fibonacci LFSR core; build with LFSR_CTRL_LOCKUP_EN for the lockup variant.
module tb_lfsr_ctrl;

`ifdef LFSR_CTRL_LOCKUP_EN
    localparam bit LK = 1'b1;
`else
    localparam bit LK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       lfsr_load;
    logic [7:0] lfsr_seed;
    logic       lfsr_step;
    logic [7:0] lfsr_taps;
    logic [7:0] core_q = 8'h00;
    logic       busy;
    logic       done;
    logic       lockup;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int load_cnt = 0;
    int step_cnt = 0;
    int done_cnt = 0;
    int overlap = 0;
    int s0;
    int d0;
    int l0;
    logic [7:0] samples[$];
    int step_cyc[$];

    lfsr_ctrl #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed), .lfsr_step(lfsr_step),
        .lfsr_taps(lfsr_taps), .lfsr_q(core_q),
        .busy(busy), .done(done), .lockup(lockup)
    );

    always #5 clk = ~clk;

    // Core model plus event recorders.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (lfsr_load)      core_q <= lfsr_seed;
        else if (lfsr_step) core_q <= {core_q[6:0], ^(core_q & lfsr_taps)};
        if (lfsr_load) load_cnt <= load_cnt + 1;
        if (lfsr_step) begin
            step_cnt <= step_cnt + 1;
            step_cyc.push_back(cyc);
        end
        if (done) done_cnt <= done_cnt + 1;
        if (lfsr_load && lfsr_step) overlap <= overlap + 1;
        if (out_valid && out_ready && ena) samples.push_back(out_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [7:0] d);
        int n = 0;
        cmd_op = op;
        cmd_data = d;
        cmd_valid = 1'b1;
        #1;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accept", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(input int max);
        int n = 0;
        while (out_valid !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("valid_seen", out_valid, 1);
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        while (done !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done, 1);
    endtask

    initial begin
        // Reset and idle values
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("rst_taps", lfsr_taps, 8'hB8);
        chk("rst_seed", lfsr_seed, 8'h01);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_lockup", lockup, 0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_done", done, 0);

        // LOAD 0x5A
        send_cmd(2'b00, 8'h5A);
        chk("load_pulse", lfsr_load, 1);
        chk("load_seed", lfsr_seed, 8'h5A);
        chk("load_cmd_ready_low", cmd_ready, 0);
        chk("load_busy", busy, 1);
        tick();
        chk("load_cmd_ready_back", cmd_ready, 1);
        chk("load_pulse_end", lfsr_load, 0);
        chk("load_count", load_cnt, 1);
        chk("load_core", core_q, 8'h5A);

        // TAPS 0x8E, LOAD 0x01, RUN 4 with out_ready high
        send_cmd(2'b01, 8'h8E);
        chk("taps_value", lfsr_taps, 8'h8E);
        send_cmd(2'b00, 8'h01);
        out_ready = 1'b1;
        samples.delete();
        step_cyc.delete();
        s0 = step_cnt;
        d0 = done_cnt;
        send_cmd(2'b10, 8'h04);
        chk("run_first_step", lfsr_step, 1);
        wait_done(40);
        chk("run4_busy_at_done", busy, 0);
        tick();
        chk("run4_done_clears", done, 0);
        chk("run4_nsamples", samples.size(), 4);
        chk("run4_s0", samples[0], 8'h02);
        chk("run4_s1", samples[1], 8'h05);
        chk("run4_s2", samples[2], 8'h0B);
        chk("run4_s3", samples[3], 8'h16);
        chk("run4_steps", step_cnt - s0, 4);
        chk("run4_gap0", step_cyc[1] - step_cyc[0], 3);
        chk("run4_gap1", step_cyc[2] - step_cyc[1], 3);
        chk("run4_gap2", step_cyc[3] - step_cyc[2], 3);
        chk("run4_done_once", done_cnt - d0, 1);

        // RUN 3, stall sample 2 for 10 cycles
        out_ready = 1'b0;
        samples.delete();
        s0 = step_cnt;
        send_cmd(2'b10, 8'h03);
        wait_valid(10);
        chk("run3_s0", out_data, 8'h2C);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        wait_valid(10);
        chk("run3_s1", out_data, 8'h58);
        repeat (10) @(negedge clk);
        chk("run3_stall_data", out_data, 8'h58);
        chk("run3_stall_valid", out_valid, 1);
        chk("run3_stall_steps", step_cnt - s0, 2);
        out_ready = 1'b1;
        wait_done(20);
        tick();
        chk("run3_nsamples", samples.size(), 3);
        chk("run3_s2", samples[2], 8'hB1);
        chk("run3_steps", step_cnt - s0, 3);

        // RUN 5, blocked RUN mid-run, STOP during HOLD of sample 2
        out_ready = 1'b0;
        d0 = done_cnt;
        send_cmd(2'b10, 8'h05);
        wait_valid(10);
        chk("run5_s0", out_data, 8'h63);
        cmd_op = 2'b10;
        cmd_data = 8'h07;
        cmd_valid = 1'b1;
        #1;
        chk("run_midrun_ready", cmd_ready, 0);
        tick();
        cmd_valid = 1'b0;
        chk("run_midrun_hold_data", out_data, 8'h63);
        chk("run_midrun_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        wait_valid(10);
        chk("run5_s1", out_data, 8'hC7);
        cmd_op = 2'b11;
        cmd_valid = 1'b1;
        #1;
        chk("stop_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        chk("stop_valid_drop", out_valid, 0);
        chk("stop_busy", busy, 0);
        s0 = step_cnt;
        repeat (5) tick();
        chk("stop_no_done", done_cnt - d0, 0);
        chk("stop_no_step", step_cnt - s0, 0);

        // ena low freezes a run in HOLD
        out_ready = 1'b1;
        samples.delete();
        d0 = done_cnt;
        send_cmd(2'b10, 8'h02);
        wait_valid(10);
        ena = 1'b0;
        s0 = step_cnt;
        repeat (5) @(negedge clk);
        chk("ena_nsamples", samples.size(), 0);
        chk("ena_valid_hold", out_valid, 1);
        chk("ena_data_hold", out_data, 8'h8F);
        chk("ena_no_step", step_cnt - s0, 0);
        chk("ena_step_low", lfsr_step, 0);
        cmd_op = 2'b11;
        #1;
        chk("ena_cmd_ready_low", cmd_ready, 0);
        cmd_op = 2'b00;
        @(negedge clk);
        ena = 1'b1;
        wait_done(20);
        tick();
        chk("ena_nsamples_after", samples.size(), 2);
        chk("ena_s0", samples[0], 8'h8F);
        chk("ena_s1", samples[1], 8'h1E);
        chk("ena_done_once", done_cnt - d0, 1);

        // RUN 0 means 256 steps
        samples.delete();
        s0 = step_cnt;
        send_cmd(2'b10, 8'h00);
        wait_done(1000);
        tick();
        chk("run0_steps", step_cnt - s0, 256);
        chk("run0_nsamples", samples.size(), 256);

        // Zero seed and zero-state handling
        send_cmd(2'b00, 8'h00);
        chk("zero_load_seed", lfsr_seed, LK ? 8'h01 : 8'h00);
        chk("zero_load_lockup", lockup, LK);
        tick();
        send_cmd(2'b00, 8'h33);
        chk("load33_seed", lfsr_seed, 8'h33);
        chk("load33_lockup_clear", lockup, 0);
        tick();
        send_cmd(2'b01, 8'h00);
        send_cmd(2'b00, 8'h80);
        tick();
        samples.delete();
        l0 = load_cnt;
        out_ready = 1'b1;
        send_cmd(2'b10, 8'h01);
        wait_done(20);
        tick();
        chk("zstate_sample", samples[0], 8'h00);
        chk("zstate_lockup", lockup, LK);
        chk("zstate_reloads", load_cnt - l0, LK ? 1 : 0);
        chk("zstate_core", core_q, LK ? 8'h01 : 8'h00);

        // Reset in the middle of a run
        out_ready = 1'b0;
        send_cmd(2'b10, 8'h05);
        wait_valid(10);
        rst_n = 1'b0;
        tick();
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_taps", lfsr_taps, 8'hB8);
        chk("midrst_seed", lfsr_seed, 8'h01);
        chk("midrst_out_data", out_data, 8'h00);
        chk("midrst_lockup", lockup, 0);
        chk("midrst_cmd_ready", cmd_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("midrst_ready_back", cmd_ready, 1);

        chk("load_step_overlap", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
